// File: rtl/iohub_pkg.sv
// Shared command bytes and FSM encoding for the IO hub frame receiver.
// Pure declarations; no logic, no latency, no flow control.
package iohub_pkg;

    localparam logic [7:0] CMD_WR   = 8'h80;
    localparam logic [7:0] CMD_ADDR = 8'h81;
    localparam logic [7:0] CMD_STS  = 8'h40;
    localparam logic [7:0] CMD_RDY  = 8'h20;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iohub_byte_timer.sv
// Inter-byte watchdog: expire_o pulses when en_i has been held for TIMEOUT_CYC cycles without clr_i.
// Expire is combinational from the count; no backpressure.
module iohub_byte_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk_cmt,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A clear in the expiring cycle wins: the byte arrived just in time.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            expire_o = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_cmt) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/iohub_frame_rx.sv
// UART byte stream -> framed single-beat bus writes; stb_o one cycle after the last data byte.
// A word completing while a request is still unacknowledged is dropped and flagged in ovf_o.
module iohub_frame_rx
    import iohub_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk_cmt,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_err_i,
    input  logic              clr_i,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic              ack_i,
    output logic              busy_o,
    output logic              sts_o,
    output logic              rdy_o,
    output logic              err_o,
    output logic              ovf_o
);

    localparam int NA   = ADDR_W / 8;
    localparam int NB   = DATA_W / 8;
    localparam int MAXB = max2(NA, NB);
    localparam int CW   = $clog2(MAXB + 1);
    localparam int AW   = max2(DATA_W, ADDR_W);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     asm_q, asm_d, asm_nx;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              stb_q, stb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              sts_q, sts_d, rdy_q, rdy_d, err_q, err_d, ovf_q, ovf_d;
    logic              sts_set, rdy_set, ovf_set, word_done;
    logic [CW-1:0]     last_cnt;
    logic              expire;

    iohub_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk_cmt  (clk_cmt),
        .rst      (rst),
        .clr_i    (rx_valid_i),
        .en_i     (state_q != ST_IDLE),
        .expire_o (expire)
    );

    assign asm_nx   = (asm_q << 8) | AW'(rx_byte_i);
    assign last_cnt = (state_q == ST_ADDR) ? CW'(NA - 1) : CW'(NB - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        ptr_d     = ptr_q;
        stb_d     = stb_q;
        addr_d    = addr_q;
        dat_d     = dat_q;
        err_d     = 1'b0;
        sts_set   = 1'b0;
        rdy_set   = 1'b0;
        ovf_set   = 1'b0;
        word_done = 1'b0;

        if (stb_q && ack_i) stb_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_err_i) err_d = 1'b1;
                if (rx_valid_i) begin
                    cnt_d = '0;
                    case (rx_byte_i)
                        CMD_WR:   state_d = ST_DATA;
                        CMD_ADDR: state_d = ST_ADDR;
                        CMD_STS:  sts_set = 1'b1;
                        CMD_RDY:  rdy_set = 1'b1;
                        default:  err_d   = 1'b1;
                    endcase
                end
            end
            ST_ADDR, ST_DATA: begin
                if (rx_err_i || expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (rx_valid_i) begin
                    asm_d = asm_nx;
                    if (cnt_q == last_cnt) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (state_q == ST_ADDR) ptr_d = asm_nx[ADDR_W-1:0];
                        else                    word_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A same-cycle ack frees the output register for the new word.
        if (word_done) begin
            if (!stb_q || ack_i) begin
                stb_d  = 1'b1;
                dat_d  = asm_nx[DATA_W-1:0];
                addr_d = ptr_q;
                ptr_d  = ptr_q + ADDR_W'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end

        sts_d = (sts_q & ~clr_i) | sts_set;
        rdy_d = (rdy_q & ~clr_i) | rdy_set;
        ovf_d = (ovf_q & ~clr_i) | ovf_set;
    end

    always_ff @(posedge clk_cmt) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            ptr_q   <= '0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            sts_q   <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ptr_q   <= ptr_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            sts_q   <= sts_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign stb_o  = stb_q;
    assign we_o   = stb_q;
    assign addr_o = addr_q;
    assign dat_o  = dat_q;
    assign busy_o = (state_q != ST_IDLE);
    assign sts_o  = sts_q;
    assign rdy_o  = rdy_q;
    assign err_o  = err_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_iohub_frame_rx.sv
// Directed bench for iohub_frame_rx (DATA_W=16, ADDR_W=16, short timeout).
module tb_iohub_frame_rx;

    localparam int TO = 20;

    logic        clk_cmt = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        rx_err_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        stb_o, we_o, busy_o, sts_o, rdy_o, err_o, ovf_o;
    logic [15:0] addr_o, dat_o;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] wr_q[$];

    iohub_frame_rx #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_cmt    (clk_cmt),
        .rst        (rst),
        .rx_valid_i (rx_valid_i),
        .rx_byte_i  (rx_byte_i),
        .rx_err_i   (rx_err_i),
        .clr_i      (clr_i),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .dat_o      (dat_o),
        .ack_i      (ack_i),
        .busy_o     (busy_o),
        .sts_o      (sts_o),
        .rdy_o      (rdy_o),
        .err_o      (err_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk_cmt = ~clk_cmt;

    // Log every accepted bus write as {addr, dat}.
    always @(posedge clk_cmt) begin
        if (!rst && stb_o && ack_i) wr_q.push_back({addr_o, dat_o});
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_cmt);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_cmt);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic ack_pulse();
        ack_i = 1'b1;
        @(posedge clk_cmt);
        #1;
        ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid_i = 1'b0; rx_err_i = 1'b0; clr_i = 1'b0; ack_i = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        wr_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({stb_o, we_o, busy_o, sts_o, rdy_o, err_o, ovf_o} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0000000", {stb_o, we_o, busy_o, sts_o, rdy_o, err_o, ovf_o});
        else n_pass++;
        n_total++;
        if ({addr_o, dat_o} !== 32'h0) $display("FAIL reset_bus: got %h want 00000000", {addr_o, dat_o});
        else n_pass++;
    endtask

    task automatic test_single_write();
        do_reset();
        send_byte(8'h80);
        send_byte(8'h12);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL t1_busy: got %b want 1", busy_o); else n_pass++;
        send_byte(8'h34);
        n_total++;
        if ({stb_o, we_o, busy_o} !== 3'b110) $display("FAIL t1_latency: stb/we/busy got %b want 110", {stb_o, we_o, busy_o});
        else n_pass++;
        n_total++;
        if ({addr_o, dat_o} !== 32'h0000_1234) $display("FAIL t1_bus: got %h want 00001234", {addr_o, dat_o});
        else n_pass++;
        wait_cycles(1);
        n_total++;
        if (stb_o !== 1'b1) $display("FAIL t1_hold: stb got %b want 1", stb_o); else n_pass++;
        ack_pulse();
        n_total++;
        if (stb_o !== 1'b0) $display("FAIL t1_drop: stb got %b want 0", stb_o); else n_pass++;
        n_total++;
        if (wr_q.size() != 1 || wr_q[0] !== 32'h0000_1234)
            $display("FAIL t1_writes: got n=%0d first=%h want n=1 00001234", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_set_addr();
        do_reset();
        ack_i = 1'b1;
        send_byte(8'h81); send_byte(8'h00); send_byte(8'h10);
        n_total++;
        if ({stb_o, busy_o} !== 2'b00) $display("FAIL t2_addr_noreq: stb/busy got %b want 00", {stb_o, busy_o});
        else n_pass++;
        send_byte(8'h80); send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h80); send_byte(8'hCC); send_byte(8'hDD);
        wait_cycles(2);
        ack_i = 1'b0;
        n_total++;
        if (wr_q.size() != 2 || wr_q[0] !== 32'h0010_AABB || wr_q[1] !== 32'h0011_CCDD)
            $display("FAIL t2_writes: got n=%0d %h %h want 0010aabb 0011ccdd", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 32'hx, (wr_q.size() > 1) ? wr_q[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        ack_i = 1'b1;
        send_byte(8'h81); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h80); send_byte(8'h03); send_byte(8'h04);
        wait_cycles(2);
        ack_i = 1'b0;
        n_total++;
        if (wr_q.size() != 2 || wr_q[0] !== 32'hFFFF_0102 || wr_q[1] !== 32'h0000_0304)
            $display("FAIL t3_wrap: got n=%0d %h %h want ffff0102 00000304", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 32'hx, (wr_q.size() > 1) ? wr_q[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h80);
        send_byte(8'h12);
        wait_cycles(TO - 1);
        n_total++;
        if ({err_o, busy_o} !== 2'b01) $display("FAIL t4_before_to: err/busy got %b want 01", {err_o, busy_o});
        else n_pass++;
        wait_cycles(1);
        n_total++;
        if ({err_o, busy_o, stb_o} !== 3'b100) $display("FAIL t4_at_to: err/busy/stb got %b want 100", {err_o, busy_o, stb_o});
        else n_pass++;
        wait_cycles(1);
        n_total++;
        if (err_o !== 1'b0) $display("FAIL t4_pulse: err got %b want 0", err_o); else n_pass++;
        ack_i = 1'b1;
        send_byte(8'h80); send_byte(8'h56); send_byte(8'h78);
        wait_cycles(2);
        ack_i = 1'b0;
        n_total++;
        if (wr_q.size() != 1 || wr_q[0] !== 32'h0000_5678)
            $display("FAIL t4_after: got n=%0d %h want 00005678", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        send_byte(8'h80); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h80); send_byte(8'h33); send_byte(8'h44);
        n_total++;
        if ({stb_o, ovf_o, addr_o, dat_o} !== {2'b11, 32'h0000_1122})
            $display("FAIL t5_ovf: stb/ovf/bus got %b%b %h want 11 00001122", stb_o, ovf_o, {addr_o, dat_o});
        else n_pass++;
        clr_i = 1'b1;
        wait_cycles(1);
        clr_i = 1'b0;
        n_total++;
        if (ovf_o !== 1'b0) $display("FAIL t5_clr: ovf got %b want 0", ovf_o); else n_pass++;
        ack_pulse();
        ack_i = 1'b1;
        send_byte(8'h80); send_byte(8'h55); send_byte(8'h66);
        wait_cycles(2);
        ack_i = 1'b0;
        n_total++;
        if (wr_q.size() != 2 || wr_q[0] !== 32'h0000_1122 || wr_q[1] !== 32'h0001_5566)
            $display("FAIL t5_writes: got n=%0d %h %h want 00001122 00015566", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 32'hx, (wr_q.size() > 1) ? wr_q[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h80); send_byte(8'h03);
        rx_byte_i = 8'h04; rx_valid_i = 1'b1; ack_i = 1'b1;
        wait_cycles(1);
        rx_valid_i = 1'b0; ack_i = 1'b0;
        n_total++;
        if ({stb_o, ovf_o, addr_o, dat_o} !== {2'b10, 32'h0001_0304})
            $display("FAIL b2b_reload: stb/ovf/bus got %b%b %h want 10 00010304", stb_o, ovf_o, {addr_o, dat_o});
        else n_pass++;
        ack_pulse();
        n_total++;
        if (stb_o !== 1'b0 || wr_q.size() != 2 || wr_q[0] !== 32'h0000_0102 || wr_q[1] !== 32'h0001_0304)
            $display("FAIL b2b_writes: stb=%b n=%0d want stb=0 n=2 00000102 00010304", stb_o, wr_q.size());
        else n_pass++;
    endtask

    task automatic test_rx_err();
        do_reset();
        rx_err_i = 1'b1;
        wait_cycles(1);
        rx_err_i = 1'b0;
        n_total++;
        if ({err_o, busy_o} !== 2'b10) $display("FAIL rxerr_idle: err/busy got %b want 10", {err_o, busy_o});
        else n_pass++;
        send_byte(8'h80); send_byte(8'h12);
        rx_err_i = 1'b1;
        wait_cycles(1);
        rx_err_i = 1'b0;
        n_total++;
        if ({err_o, busy_o} !== 2'b10) $display("FAIL rxerr_frame: err/busy got %b want 10", {err_o, busy_o});
        else n_pass++;
        ack_i = 1'b1;
        send_byte(8'h80); send_byte(8'h34); send_byte(8'h56);
        send_byte(8'h80); send_byte(8'h80); send_byte(8'h81);
        wait_cycles(2);
        ack_i = 1'b0;
        n_total++;
        if (wr_q.size() != 2 || wr_q[0] !== 32'h0000_3456 || wr_q[1] !== 32'h0001_8081)
            $display("FAIL rxerr_writes: got n=%0d %h %h want 00003456 00018081", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 32'hx, (wr_q.size() > 1) ? wr_q[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_cmds();
        do_reset();
        send_byte(8'h40);
        send_byte(8'h20);
        n_total++;
        if ({sts_o, rdy_o, err_o} !== 3'b110) $display("FAIL t6_sts_rdy: sts/rdy/err got %b want 110", {sts_o, rdy_o, err_o});
        else n_pass++;
        send_byte(8'h7F);
        n_total++;
        if ({err_o, busy_o} !== 2'b10) $display("FAIL t6_bad_hdr: err/busy got %b want 10", {err_o, busy_o});
        else n_pass++;
        wait_cycles(1);
        n_total++;
        if (err_o !== 1'b0) $display("FAIL t6_err_pulse: err got %b want 0", err_o); else n_pass++;
        clr_i = 1'b1;
        send_byte(8'h40);
        clr_i = 1'b0;
        n_total++;
        if ({sts_o, rdy_o} !== 2'b10) $display("FAIL t6_set_wins: sts/rdy got %b want 10", {sts_o, rdy_o});
        else n_pass++;
        send_byte(8'h80); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h80); send_byte(8'h12);
        rst = 1'b1;
        wait_cycles(1);
        n_total++;
        if ({stb_o, busy_o, sts_o, rdy_o, err_o, ovf_o} !== 6'b0)
            $display("FAIL t6_mid_rst: stb/busy/sts/rdy/err/ovf got %b want 000000", {stb_o, busy_o, sts_o, rdy_o, err_o, ovf_o});
        else n_pass++;
        rst = 1'b0;
        wr_q.delete();
        ack_i = 1'b1;
        send_byte(8'h80); send_byte(8'hAB); send_byte(8'hCD);
        wait_cycles(2);
        ack_i = 1'b0;
        n_total++;
        if (wr_q.size() != 1 || wr_q[0] !== 32'h0000_ABCD)
            $display("FAIL t6_after_rst: got n=%0d %h want 0000abcd", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx);
        else n_pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_single_write();
        test_set_addr();
        test_wrap();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_rx_err();
        test_cmds();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
